// File: rtl/int_requester.sv
// Device-side interrupt source: turns event strobes on three channels into IR pulses and
// tracks each request through acknowledge and ERET. Optional re-pulse on missing ack: INT_RETRY_EN.
module int_requester #(
    parameter int PULSE_LEN    = 2,
    parameter int RETRY_CYCLES = 64,
    parameter int Q_W          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] event_in,
    input  logic       int_sig,
    input  logic [1:0] which_int,
    input  logic       ex_eret,
    output logic [2:0] IR_out,
    output logic [2:0] pending,
    output logic [2:0] in_service,
    output logic [2:0] overrun,
    output logic [1:0] depth,
    output logic [5:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_ACK = 2'd2,
        SERVICE  = 2'd3
    } ch_state_t;

    localparam int              PC_W       = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PC_W-1:0] PULSE_LOAD = PC_W'(PULSE_LEN - 1);
    localparam logic [Q_W-1:0]  Q_MAX      = '1;
`ifdef INT_RETRY_EN
    localparam int              RT_W       = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam logic [RT_W-1:0] RETRY_LOAD = RT_W'(RETRY_CYCLES - 1);
`endif

    ch_state_t       state     [3];
    logic [PC_W-1:0] pulse_cnt [3];
    logic [Q_W-1:0]  queue     [3];
    logic [Q_W-1:0]  queue_nxt [3];
    logic [1:0]      stk       [3];
`ifdef INT_RETRY_EN
    logic [RT_W-1:0] retry_cnt [3];
`endif
    logic [2:0] event_prev;
    logic       armed;

    logic [2:0] evt, enq, take, popped, launch_q, ovf;
    logic       pop, push, push_room;
    logic [1:0] top_ch, depth_pop, push_ch;

    // CPU handshake: a cycle with int_sig=1 and which_int=i+1 acknowledges channel i if it is
    // in PULSE or WAIT_ACK (otherwise it is ignored); ex_eret pops the innermost acknowledged
    // channel. Both are single-cycle strobes with no back-pressure; pop is applied before push.
    always_comb begin
        evt    = event_in & ~event_prev & {3{armed}};
        pop    = ex_eret && (depth != 2'd0);
        case (depth)
            2'd3:    top_ch = stk[2];
            2'd2:    top_ch = stk[1];
            default: top_ch = stk[0];
        endcase
        depth_pop = depth - {1'b0, pop};
        push_room = (depth_pop != 2'd3);
        push_ch   = which_int - 2'd1;
        take      = '0;
        popped    = '0;
        enq       = '0;
        launch_q  = '0;
        ovf       = '0;
        for (int i = 0; i < 3; i++) begin
            take[i]      = int_sig && (which_int == 2'(i + 1)) && push_room &&
                           ((state[i] == PULSE) || (state[i] == WAIT_ACK));
            popped[i]    = pop && (top_ch == 2'(i));
            enq[i]       = evt[i] && ((state[i] != IDLE) || (queue[i] != '0));
            launch_q[i]  = (queue[i] != '0) &&
                           ((state[i] == IDLE) || ((state[i] == SERVICE) && popped[i]));
            ovf[i]       = enq[i] && (queue[i] == Q_MAX);
            queue_nxt[i] = queue[i] - Q_W'(launch_q[i]) + Q_W'(enq[i] && !ovf[i]);
        end
        push = |take;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                state[i]     <= IDLE;
                pulse_cnt[i] <= '0;
                queue[i]     <= '0;
                stk[i]       <= '0;
`ifdef INT_RETRY_EN
                retry_cnt[i] <= '0;
`endif
            end
            IR_out     <= '0;
            overrun    <= '0;
            event_prev <= '0;
            armed      <= 1'b0;
            depth      <= '0;
        end else begin
            // The first cycle after reset only loads event_prev, so a line already high is not an edge.
            event_prev <= event_in;
            armed      <= 1'b1;
            if (push) begin
                stk[depth_pop] <= push_ch;
            end
            depth <= depth_pop + {1'b0, push};
            for (int i = 0; i < 3; i++) begin
                queue[i] <= queue_nxt[i];
                if (ovf[i]) begin
                    overrun[i] <= 1'b1;
                end
                case (state[i])
                    IDLE: begin
                        if (evt[i] || (queue[i] != '0)) begin
                            state[i]     <= PULSE;
                            IR_out[i]    <= 1'b1;
                            pulse_cnt[i] <= PULSE_LOAD;
                        end
                    end
                    PULSE: begin
                        if (take[i]) begin
                            state[i]  <= SERVICE;
                            IR_out[i] <= 1'b0;
                        end else if (pulse_cnt[i] == '0) begin
                            state[i]  <= WAIT_ACK;
                            IR_out[i] <= 1'b0;
`ifdef INT_RETRY_EN
                            retry_cnt[i] <= RETRY_LOAD;
`endif
                        end else begin
                            pulse_cnt[i] <= pulse_cnt[i] - 1'b1;
                        end
                    end
                    WAIT_ACK: begin
                        if (take[i]) begin
                            state[i] <= SERVICE;
`ifdef INT_RETRY_EN
                        end else if (retry_cnt[i] == '0) begin
                            state[i]     <= PULSE;
                            IR_out[i]    <= 1'b1;
                            pulse_cnt[i] <= PULSE_LOAD;
                        end else begin
                            retry_cnt[i] <= retry_cnt[i] - 1'b1;
`endif
                        end
                    end
                    SERVICE: begin
                        if (popped[i]) begin
                            if (queue[i] != '0) begin
                                state[i]     <= PULSE;
                                IR_out[i]    <= 1'b1;
                                pulse_cnt[i] <= PULSE_LOAD;
                            end else begin
                                state[i] <= IDLE;
                            end
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        pending    = '0;
        in_service = '0;
        for (int i = 0; i < 3; i++) begin
            pending[i]    = (state[i] == PULSE) || (state[i] == WAIT_ACK);
            in_service[i] = (state[i] == SERVICE);
        end
        state_dbg = {state[2], state[1], state[0]};
    end

endmodule

// File: tb/tb_int_requester.sv
// Bench for int_requester: directed scenarios plus random traffic, each cycle checked against a
// queue/counter-level model of the request lifecycle.
module tb_int_requester;

    localparam int PL    = 2;
    localparam int RETRY = 8;
    localparam int QMAX  = 3;

    logic        clk;
    logic        rst;
    logic [2:0]  event_in;
    logic        int_sig;
    logic [1:0]  which_int;
    logic        ex_eret;
    logic [2:0]  IR_out, pending, in_service, overrun;
    logic [1:0]  depth;
    logic [5:0]  state_dbg;
    logic [13:0] dut_out;

    int n_vec = 0;
    int n_err = 0;

    // Model: IR cycles left, awaiting ack, retry countdown, backlog of events, sticky overrun,
    // and the in-service stack as a plain queue.
    int         m_ir    [3];
    bit         m_wait  [3];
    int         m_retry [3];
    int         m_back  [3];
    bit         m_ovf   [3];
    int         m_stk   [$];
    logic [2:0] m_prev;
    bit         m_armed;
    logic [13:0] exp_q  [$];

    int_requester #(
        .PULSE_LEN(PL),
        .RETRY_CYCLES(RETRY),
        .Q_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .event_in(event_in),
        .int_sig(int_sig),
        .which_int(which_int),
        .ex_eret(ex_eret),
        .IR_out(IR_out),
        .pending(pending),
        .in_service(in_service),
        .overrun(overrun),
        .depth(depth),
        .state_dbg(state_dbg)
    );

    assign dut_out = {IR_out, pending, in_service, overrun, depth};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    function automatic bit in_stk(int c);
        foreach (m_stk[k]) if (m_stk[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ir[i] = 0; m_wait[i] = 0; m_retry[i] = 0; m_back[i] = 0; m_ovf[i] = 0;
        end
        m_stk.delete();
        exp_q.delete();
        m_prev  = 3'b000;
        m_armed = 1'b0;
    endfunction

    function automatic void enqueue(int i, int b0);
        if (b0 == QMAX) m_ovf[i] = 1'b1;
        else m_back[i]++;
    endfunction

    function automatic void model_edge(logic [2:0] ev, logic is, logic [1:0] wi, logic er);
        logic [2:0] edges;
        int pre_ir [3];
        bit pre_wait [3];
        int b0 [3];
        bit svc [3];
        int acked, popped, w;
        edges = m_armed ? (ev & ~m_prev) : 3'b000;
        m_prev  = ev;
        m_armed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pre_ir[i] = m_ir[i]; pre_wait[i] = m_wait[i]; b0[i] = m_back[i]; svc[i] = in_stk(i);
        end
        w = int'(wi);
        acked = -1;
        if (is && w != 0 && (pre_ir[w-1] > 0 || pre_wait[w-1])) acked = w - 1;
        popped = -1;
        if (er && m_stk.size() > 0) popped = m_stk.pop_back();
        if (acked >= 0 && m_stk.size() < 3) m_stk.push_back(acked);
        else acked = -1;
        for (int i = 0; i < 3; i++) begin
            if (i == acked) begin
                m_ir[i] = 0; m_wait[i] = 0;
            end else if (i == popped) begin
                if (b0[i] > 0) begin m_back[i]--; m_ir[i] = PL; end
            end else if (pre_ir[i] > 0) begin
                m_ir[i]--;
                if (m_ir[i] == 0) begin m_wait[i] = 1'b1; m_retry[i] = RETRY; end
            end else if (pre_wait[i]) begin
`ifdef INT_RETRY_EN
                m_retry[i]--;
                if (m_retry[i] == 0) begin m_wait[i] = 1'b0; m_ir[i] = PL; end
`endif
            end else if (!svc[i]) begin
                if (b0[i] > 0) begin
                    m_back[i]--; m_ir[i] = PL;
                end else if (edges[i]) begin
                    m_ir[i] = PL; edges[i] = 1'b0;
                end
            end
            if (edges[i]) enqueue(i, b0[i]);
        end
    endfunction

    function automatic logic [13:0] model_out();
        logic [2:0] ir, pd, sv, ov;
        for (int i = 0; i < 3; i++) begin
            ir[i] = (m_ir[i] > 0);
            pd[i] = (m_ir[i] > 0) || m_wait[i];
            sv[i] = in_stk(i);
            ov[i] = m_ovf[i];
        end
        return {ir, pd, sv, ov, 2'(m_stk.size())};
    endfunction

    // Driver: apply one cycle of inputs, advance the model at the edge, return on the next negedge.
    task automatic step(input logic [2:0] ev, input logic is, input logic [1:0] wi, input logic er);
        event_in = ev; int_sig = is; which_int = wi; ex_eret = er;
        @(posedge clk);
        model_edge(ev, is, wi, er);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [13:0] e;
        rst = 1'b1; event_in = 3'b100; int_sig = 1'b0; which_int = 2'd0; ex_eret = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (dut_out !== 14'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected %h", dut_out, 14'd0);
        end
        rst = 1'b1;
        // Line 2 is already high when reset releases: no request may be raised.
        for (int s = 1; s <= 3; s++) begin
            step(3'b100, 1'b0, 2'd0, 1'b0);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out !== e || IR_out !== 3'b000) begin
                n_err++; $display("FAIL reset_high_line step%0d: got %h expected %h", s, dut_out, e);
            end
        end
        step(3'b000, 1'b0, 2'd0, 1'b0);
        void'(exp_q.pop_front());
    endtask

    task automatic test_single_pulse();
        logic [13:0] e;
        logic [3:0] ir_seq;
        ir_seq = 4'b0011;
        for (int s = 0; s < 4; s++) begin
            step(3'b001, 1'b0, 2'd0, 1'b0);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out !== e || IR_out[0] !== ir_seq[s] || pending[0] !== 1'b1) begin
                n_err++; $display("FAIL single_pulse step%0d: got %h expected %h", s, dut_out, e);
            end
        end
    endtask

    task automatic test_ack_eret();
        logic [13:0] e;
        step(3'b001, 1'b1, 2'd1, 1'b0);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || in_service !== 3'b001 || depth !== 2'd1 || pending[0] !== 1'b0) begin
            n_err++; $display("FAIL ack: got %h expected %h", dut_out, e);
        end
        step(3'b000, 1'b0, 2'd0, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || in_service !== 3'b000 || depth !== 2'd0) begin
            n_err++; $display("FAIL eret: got %h expected %h", dut_out, e);
        end
        step(3'b000, 1'b0, 2'd0, 1'b0);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || pending !== 3'b000) begin
            n_err++; $display("FAIL after_eret_idle: got %h expected %h", dut_out, e);
        end
    endtask

    task automatic test_nesting();
        logic [13:0] e;
        logic [2:0] ev [8];
        logic is [8];
        logic [1:0] wi [8];
        logic er [8];
        ev = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b101, 3'b101, 3'b101, 3'b101};
        is = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        wi = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int s = 0; s < 8; s++) begin
            step(ev[s], is[s], wi[s], er[s]);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out !== e) begin
                n_err++; $display("FAIL nesting_setup step%0d: got %h expected %h", s, dut_out, e);
            end
        end
        n_vec++;
        if (depth !== 2'd2 || in_service !== 3'b101) begin
            n_err++; $display("FAIL nesting_depth2: got depth %0d svc %b expected 2 101", depth, in_service);
        end
        step(3'b101, 1'b0, 2'd0, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || in_service !== 3'b001 || depth !== 2'd1) begin
            n_err++; $display("FAIL nesting_eret1: got %h expected %h", dut_out, e);
        end
        step(3'b000, 1'b0, 2'd0, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || in_service !== 3'b000 || depth !== 2'd0) begin
            n_err++; $display("FAIL nesting_eret2: got %h expected %h", dut_out, e);
        end
    endtask

    task automatic test_overrun();
        logic [13:0] e;
        logic prev_ir;
        int rises;
        step(3'b010, 1'b0, 2'd0, 1'b0);
        void'(exp_q.pop_front());
        step(3'b010, 1'b0, 2'd0, 1'b0);
        void'(exp_q.pop_front());
        step(3'b010, 1'b1, 2'd2, 1'b0);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || IR_out[1] !== 1'b0 || in_service !== 3'b010) begin
            n_err++; $display("FAIL ack_in_pulse: got %h expected %h", dut_out, e);
        end
        for (int k = 0; k < 4; k++) begin
            step(3'b000, 1'b0, 2'd0, 1'b0);
            void'(exp_q.pop_front());
            step(3'b010, 1'b0, 2'd0, 1'b0);
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out !== e) begin
                n_err++; $display("FAIL queue_fill event%0d: got %h expected %h", k, dut_out, e);
            end
        end
        n_vec++;
        if (overrun !== 3'b010 || in_service !== 3'b010) begin
            n_err++; $display("FAIL overrun_flag: got ovr %b svc %b expected 010 010", overrun, in_service);
        end
        rises = 0;
        prev_ir = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 4; s++) begin
                step(3'b000, (s == 3), (s == 3) ? 2'd2 : 2'd0, (s == 0));
                e = exp_q.pop_front();
                n_vec++;
                if (dut_out !== e) begin
                    n_err++; $display("FAIL queue_drain k%0d s%0d: got %h expected %h", k, s, dut_out, e);
                end
                if (IR_out[1] && !prev_ir) rises++;
                prev_ir = IR_out[1];
            end
        end
        step(3'b000, 1'b0, 2'd0, 1'b1);
        e = exp_q.pop_front();
        step(3'b000, 1'b0, 2'd0, 1'b0);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || rises != 3 || pending !== 3'b000 || depth !== 2'd0) begin
            n_err++; $display("FAIL queue_drain_end: got %h rises %0d expected %h rises 3", dut_out, rises, e);
        end
    endtask

    task automatic test_pop_push();
        logic [13:0] e;
        step(3'b001, 1'b0, 2'd0, 1'b0);
        void'(exp_q.pop_front());
        step(3'b001, 1'b1, 2'd1, 1'b0);
        void'(exp_q.pop_front());
        step(3'b011, 1'b0, 2'd0, 1'b0);
        void'(exp_q.pop_front());
        step(3'b011, 1'b0, 2'd0, 1'b0);
        void'(exp_q.pop_front());
        step(3'b011, 1'b1, 2'd2, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || in_service !== 3'b010 || depth !== 2'd1 || pending !== 3'b000) begin
            n_err++; $display("FAIL pop_push: got %h expected %h", dut_out, e);
        end
        step(3'b000, 1'b0, 2'd0, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || depth !== 2'd0) begin
            n_err++; $display("FAIL pop_push_cleanup: got %h expected %h", dut_out, e);
        end
    endtask

    task automatic test_retry();
        logic [13:0] e;
        logic exp_ir;
        for (int s = 1; s <= 3 * RETRY; s++) begin
            step(3'b100, 1'b0, 2'd0, 1'b0);
            e = exp_q.pop_front();
`ifdef INT_RETRY_EN
            exp_ir = (((s - 1) % (PL + RETRY)) < PL);
`else
            exp_ir = (s <= PL);
`endif
            n_vec++;
            if (dut_out !== e || IR_out[2] !== exp_ir) begin
                n_err++; $display("FAIL retry step%0d: got %h ir %b expected %h ir %b", s, dut_out, IR_out[2], e, exp_ir);
            end
        end
        step(3'b000, 1'b1, 2'd3, 1'b0);
        void'(exp_q.pop_front());
        step(3'b000, 1'b0, 2'd0, 1'b1);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || pending !== 3'b000) begin
            n_err++; $display("FAIL retry_cleanup: got %h expected %h", dut_out, e);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [13:0] e;
        step(3'b000, 1'b0, 2'd0, 1'b0);
        void'(exp_q.pop_front());
        step(3'b001, 1'b0, 2'd0, 1'b0);
        e = exp_q.pop_front();
        n_vec++;
        if (dut_out !== e || IR_out[0] !== 1'b1) begin
            n_err++; $display("FAIL mid_pulse_setup: got %h expected %h", dut_out, e);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (dut_out !== 14'd0) begin
            n_err++; $display("FAIL reset_mid_pulse: got %h expected %h", dut_out, 14'd0);
        end
        model_reset();
        @(negedge clk);
        event_in = 3'b000;
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [13:0] e;
        logic [2:0] ev;
        int shown;
        ev = 3'b000;
        shown = 0;
        for (int s = 0; s < 1500; s++) begin
            ev = ev ^ (3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
            step(ev, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            e = exp_q.pop_front();
            n_vec++;
            if (dut_out !== e) begin
                n_err++;
                if (shown < 20) begin
                    shown++; $display("FAIL random cyc%0d: got %h expected %h", s, dut_out, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_ack_eret();
        test_nesting();
        test_overrun();
        test_pop_push();
        test_retry();
        test_reset_mid_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
